ef_smsdac_mse_dec: RTL
======================

EF_SMSDAC_MSE_DEC -- requirements
Module: ef_smsdac_mse_dec

Interface
REQ-001 Parameter NB, default 4: number of 3-level switching stages, one per code bit.
REQ-002 Parameter LIMIT, default 2: allowed magnitude of the per-stage odd-event imbalance.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 in_valid  input  1: element drive word on elem_* is valid this cycle.
REQ-006 elem_y1  input  NB: stage k upper-element drive, weight 2^k.
REQ-007 elem_y0  input  NB: stage k lower-element drive, weight 2^k.
REQ-008 elem_c  input  1: carry (extra LSB) element drive, weight 1.
REQ-009 clr  input  1: synchronous clear of imbalance counters and sticky flags.
REQ-010 out_valid  output  1: code is valid this cycle.
REQ-011 code  output  NB+1: reconstructed unsigned input code.
REQ-012 illegal  output  NB: sticky per stage; set on the illegal pattern y1=1, y0=0.
REQ-013 shape_err  output  NB: sticky per stage; set when |imbalance| exceeds LIMIT.
REQ-014 err  output  1: OR of all illegal and shape_err bits.

Function
REQ-015 Code reconstruction: code = elem_c + sum over k of 2^k*(elem_y0[k]+elem_y1[k]); range 0..2^(NB+1)-1; no overflow at NB+1 bits.
REQ-016 Pipeline: stage P1 registers the elem_* inputs and in_valid; stage P2 registers the sum and the valid bit.
REQ-017 Latency is exactly 2 cycles from in_valid to out_valid; full throughput, one word per cycle, no backpressure.
REQ-018 code holds its last value while out_valid=0.
REQ-019 Stage-k pattern classes: (y1,y0)=(0,1) is even; (1,1) is odd-low; (0,0) is odd-high; (1,0) is illegal.
REQ-020 Per-stage signed imbalance s_k, saturating, width clog2(LIMIT+2)+1, updated from the P1 register only when the registered valid bit is 1.
REQ-021 s_k update: +1 on odd-low, -1 on odd-high, unchanged on even or illegal.
REQ-022 shape_err[k] sets on the cycle after s_k reaches |s_k| = LIMIT+1.
REQ-023 s_k saturates at +/-(LIMIT+1) and never wraps.
REQ-024 illegal[k] sets on the cycle after an illegal pattern is registered at P1 with valid.
REQ-025 Sticky flags remain set until clr or rst.
REQ-026 clr zeroes all s_k and flags on the next edge.
REQ-027 clr has priority over a simultaneous update; the P2 data path is unaffected by clr.
REQ-028 err is registered and asserts in the same cycle as the flag that causes it.
REQ-029 Words with in_valid=0 produce no counter or flag effect.

Reset
REQ-030 On rst=1 at a clock edge, the block clears all pipeline valids, s_k, illegal, shape_err and err, and sets code to 0.
REQ-031 out_valid stays 0 for the first 2 cycles after rst deasserts.
REQ-032 rst mid-stream discards in-flight words: no out_valid is produced for words accepted before the reset.

Structure
REQ-033 Shared package ef_smsdac_pkg holds the default NB and LIMIT, the imbalance-width function, and the pattern-class enum (EVEN, ODD_LO, ODD_HI, ILLEGAL).
REQ-034 One sub-module, ef_smsdac_mse_dec_chk, is instantiated NB times.
REQ-035 Each ef_smsdac_mse_dec_chk instance holds one stage's classifier, s_k counter and sticky flags.
REQ-036 The top-level module holds the P1/P2 pipeline, the weighted adder and the err reduction.

Verification
REQ-037 Scenario 1 (NB=4): apply elem_c=1, y1=0000, y0=1111, in_valid for one cycle -> code=16 with out_valid exactly 2 cycles later, and err stays 0.
REQ-038 Scenario 2: apply y1=1111, y0=1111, elem_c=1 -> code=31. Then apply y1=y0=0000, elem_c=0 -> code=0.
REQ-039 Scenario 3: drive stage 0 odd-low on 3 consecutive valid words with LIMIT=2 -> shape_err[0]=1 and err=1 after the third word; the flag persists until clr.
REQ-040 Scenario 4: alternate odd-low and odd-high on stage 2 for 100 words -> s_2 stays within [-1,1] and shape_err stays 0.
REQ-041 Scenario 5: drive y1[1]=1, y0[1]=0 for one valid word -> illegal=0010 and err=1. Then assert clr -> all flags return to 0 on the next cycle.
REQ-042 Scenario 6: assert rst for one cycle while 2 words are in flight -> no out_valid is produced for those words, and code=0.

Source files
------------

// File: rtl/ef_smsdac_pkg.sv
// Shared definitions for the segmented mismatch-shaping DAC element decoder.
// Holds default sizes, the imbalance counter width and the stage pattern classifier.
package ef_smsdac_pkg;

  localparam int NB_DEF    = 4;
  localparam int LIMIT_DEF = 2;

  typedef enum logic [1:0] {EVEN, ODD_LO, ODD_HI, ILLEGAL} pat_e;

  // Signed width that holds +/-(limit+1) without wrapping.
  function automatic int imb_w(input int limit);
    return $clog2(limit + 2) + 1;
  endfunction

  function automatic pat_e classify(input logic y1, input logic y0);
    case ({y1, y0})
      2'b01:   return EVEN;
      2'b11:   return ODD_LO;
      2'b00:   return ODD_HI;
      default: return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/ef_smsdac_mse_dec_chk.sv
// Per-stage shaping monitor: classifies the registered element pair, tracks the
// saturating odd-event imbalance and keeps sticky illegal / shape flags.
module ef_smsdac_mse_dec_chk
  import ef_smsdac_pkg::*;
#(
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic i_vld,
  input  logic i_y1,
  input  logic i_y0,
  output logic o_illegal,
  output logic o_shape_err,
  output logic o_illegal_nxt,
  output logic o_shape_nxt
);

  localparam int SW = imb_w(LIMIT);
  localparam logic signed [SW-1:0] S_ONE = SW'(1);
  localparam logic signed [SW-1:0] S_MAX = SW'(LIMIT + 1);
  localparam logic signed [SW-1:0] S_MIN = -S_MAX;

  logic signed [SW-1:0] r_s;
  logic signed [SW-1:0] w_s_nxt;
  logic                 r_illegal;
  logic                 r_shape_err;
  logic                 w_ill_nxt;
  logic                 w_shp_nxt;
  pat_e                 w_pat;

  always_comb begin
    w_pat   = classify(i_y1, i_y0);
    w_s_nxt = r_s;
    if (i_vld) begin
      case (w_pat)
        ODD_LO:  if (r_s != S_MAX) w_s_nxt = r_s + S_ONE;
        ODD_HI:  if (r_s != S_MIN) w_s_nxt = r_s - S_ONE;
        default: w_s_nxt = r_s;
      endcase
    end
    // Shape flag trails the counter by one edge: it looks at the current count.
    w_shp_nxt = r_shape_err | (r_s == S_MAX) | (r_s == S_MIN);
    w_ill_nxt = r_illegal | (i_vld && (w_pat == ILLEGAL));
    if (clr) begin
      w_s_nxt   = '0;
      w_shp_nxt = 1'b0;
      w_ill_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= '0;
      r_illegal   <= 1'b0;
      r_shape_err <= 1'b0;
    end else begin
      r_s         <= w_s_nxt;
      r_illegal   <= w_ill_nxt;
      r_shape_err <= w_shp_nxt;
    end
  end

  assign o_illegal     = r_illegal;
  assign o_shape_err   = r_shape_err;
  assign o_illegal_nxt = w_ill_nxt;
  assign o_shape_nxt   = w_shp_nxt;

endmodule

// File: rtl/ef_smsdac_mse_dec.sv
// Segmented mismatch-shaping DAC element decoder: two-stage code reconstruction
// pipeline plus per-stage shaping monitors and an aggregated error flag.
module ef_smsdac_mse_dec
  import ef_smsdac_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [NB-1:0] elem_y1,
  input  logic [NB-1:0] elem_y0,
  input  logic          elem_c,
  input  logic          clr,
  output logic          out_valid,
  output logic [NB:0]   code,
  output logic [NB-1:0] illegal,
  output logic [NB-1:0] shape_err,
  output logic          err
);

  logic [1:0]    r_vld_pipe;
  logic [NB-1:0] r_y1;
  logic [NB-1:0] r_y0;
  logic          r_c;
  logic [NB:0]   r_code;
  logic          r_err;
  logic [NB:0]   w_sum;
  logic [NB-1:0] w_ill_nxt;
  logic [NB-1:0] w_shp_nxt;

  // Both element rows carry binary weights, so the weighted sum is a plain add.
  assign w_sum = (NB+1)'(r_y1) + (NB+1)'(r_y0) + (NB+1)'(r_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_y1       <= '0;
      r_y0       <= '0;
      r_c        <= 1'b0;
      r_code     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], in_valid};
      r_y1       <= elem_y1;
      r_y0       <= elem_y0;
      r_c        <= elem_c;
      if (r_vld_pipe[0]) r_code <= w_sum;
      r_err      <= |(w_ill_nxt | w_shp_nxt);
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_chk
    ef_smsdac_mse_dec_chk #(.LIMIT(LIMIT)) u_chk (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .i_vld        (r_vld_pipe[0]),
      .i_y1         (r_y1[k]),
      .i_y0         (r_y0[k]),
      .o_illegal    (illegal[k]),
      .o_shape_err  (shape_err[k]),
      .o_illegal_nxt(w_ill_nxt[k]),
      .o_shape_nxt  (w_shp_nxt[k])
    );
  end

  assign out_valid = r_vld_pipe[1];
  assign code      = r_code;
  assign err       = r_err;

endmodule
